// File: rtl/pipe_ctrl_pkg.sv
// Shared types and select encodings for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  // Shadow entries carry rd at a fixed maximum width; narrower REG_AW values are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                  v;
    logic [REG_AW_MAX-1:0] rd;
    logic                  wreg;
    logic                  m2reg;
  } shadow_t;

endpackage

// File: rtl/haz_operand_chk.sv
// Per-operand hazard check: youngest matching shadow entry selects a forward or a stall.
module haz_operand_chk
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int FWD_DEPTH = 3
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  shadow_t           ent_exe,
  input  shadow_t           ent_mem,
  input  shadow_t           ent_wb,
  output logic [1:0]        sel,
  output logic              stall_req
);

  logic [REG_AW_MAX-1:0] w_rs_ext;
  logic                  w_qual;
  logic                  w_m_exe;
  logic                  w_m_mem;
  logic                  w_m_wb;

  assign w_rs_ext = REG_AW_MAX'(rs);
  assign w_qual   = id_valid & rs_used & (rs != '0);
  assign w_m_exe  = w_qual & ent_exe.v & ent_exe.wreg & (ent_exe.rd == w_rs_ext);
  assign w_m_mem  = w_qual & ent_mem.v & ent_mem.wreg & (ent_mem.rd == w_rs_ext);
  assign w_m_wb   = w_qual & ent_wb.v  & ent_wb.wreg  & (ent_wb.rd  == w_rs_ext);

  always_comb begin
    sel       = FWD_REG;
    stall_req = 1'b0;
    if (w_m_exe) begin
      // A load in EXE has no result yet, regardless of depth.
      if (!ent_exe.m2reg) sel = FWD_EXE;
      else                stall_req = 1'b1;
    end else if (w_m_mem) begin
      if (FWD_DEPTH >= 2) sel = FWD_MEM;
      else                stall_req = 1'b1;
    end else if (w_m_wb) begin
      if (FWD_DEPTH >= 3) sel = FWD_WB;
      else                stall_req = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller with an internal EXE/MEM/WB shadow pipe.
// Optional saturating stall/flush counters under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int FWD_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              exe_redirect,
  output logic              stall_en,
  output logic              flush_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  shadow_t    r_exe, r_mem, r_wb;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_stall_a, w_stall_b;

  haz_operand_chk #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_chk_a (
    .id_valid (id_valid),
    .rs       (id_rs1),
    .rs_used  (id_rs1_used),
    .ent_exe  (r_exe),
    .ent_mem  (r_mem),
    .ent_wb   (r_wb),
    .sel      (w_sel_a),
    .stall_req(w_stall_a)
  );

  haz_operand_chk #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_chk_b (
    .id_valid (id_valid),
    .rs       (id_rs2),
    .rs_used  (id_rs2_used),
    .ent_exe  (r_exe),
    .ent_mem  (r_mem),
    .ent_wb   (r_wb),
    .sel      (w_sel_b),
    .stall_req(w_stall_b)
  );

  // Outputs are held quiet during reset because the shadow pipe still holds pre-reset state.
  assign flush_id  = exe_redirect & ~rst;
  assign stall_en  = (w_stall_a | w_stall_b) & ~exe_redirect & ~rst;
  assign fwd_a_sel = rst ? FWD_REG : w_sel_a;
  assign fwd_b_sel = rst ? FWD_REG : w_sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb        <= r_mem;
      r_mem       <= r_exe;
      r_exe.v     <= id_valid & ~stall_en & ~flush_id;
      r_exe.rd    <= REG_AW_MAX'(id_rd);
      r_exe.wreg  <= id_wreg;
      r_exe.m2reg <= id_m2reg;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_id && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance at FWD_DEPTH=3, one at FWD_DEPTH=1.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_wreg, id_m2reg, exe_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_en, flush_id, stall_en1, flush_id1;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel1, fwd_b_sel1;
  logic [15:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .exe_redirect(exe_redirect),
    .stall_en(stall_en), .flush_id(flush_id), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .exe_redirect(exe_redirect),
    .stall_en(stall_en1), .flush_id(flush_id1), .fwd_a_sel(fwd_a_sel1), .fwd_b_sel(fwd_b_sel1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wreg, input logic m2reg);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wreg = wreg; id_m2reg = m2reg;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    exe_redirect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    // Reset state, with a hazard-looking ID instruction present.
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
    exe_redirect = 1'b1;
    sample();
    check("rst_stall", stall_en, 0);
    check("rst_flush", flush_id, 0);
    check("rst_sel_a", fwd_a_sel, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    step();
    rst = 1'b0;
    idle();

    // add r3 forwarded from EXE, then MEM, then WB, then regfile.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    sample();
    check("exe_fwd_a", fwd_a_sel, 2'b01);
    check("exe_fwd_stall", stall_en, 0);
    check("exe_fwd_b_nomatch", fwd_b_sel, 2'b00);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    check("mem_fwd_a", fwd_a_sel, 2'b10);
    check("mem_fwd_stall", stall_en, 0);
    step();
    sample();
    check("wb_fwd_a", fwd_a_sel, 2'b11);
    step();
    sample();
    check("retired_a", fwd_a_sel, 2'b00);

    // Load-use: one stall, then MEM forward.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    sample();
    check("lu_stall", stall_en, 1);
    check("lu_sel_b", fwd_b_sel, 2'b00);
    step();
    sample();
    check("lu_after_stall", stall_en, 0);
    check("lu_after_sel_b", fwd_b_sel, 2'b10);
    check("lu_stall_cnt", stall_cnt, PERF);
    check("lu_flush_cnt", flush_cnt, 0);

    // Same register written by EXE and MEM: youngest wins; unused operand ignored.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    step();
    set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    check("youngest_a", fwd_a_sel, 2'b01);
    check("unused_b", fwd_b_sel, 2'b00);
    check("youngest_stall", stall_en, 0);

    // Writer to r0 never matches.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
    sample();
    check("r0_sel_a", fwd_a_sel, 2'b00);
    check("r0_sel_b", fwd_b_sel, 2'b00);
    check("r0_stall", stall_en, 0);

    // FWD_DEPTH=1: EXE forward only; MEM/WB producers stall.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    check("d1_exe_sel_a", fwd_a_sel1, 2'b01);
    check("d1_exe_stall", stall_en1, 0);
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    sample();
    check("d1_mem_stall", stall_en1, 1);
    check("d1_mem_sel_b", fwd_b_sel1, 2'b00);
    step();
    sample();
    check("d1_wb_stall", stall_en1, 1);
    step();
    sample();
    check("d1_done_stall", stall_en1, 0);
    check("d1_done_sel_b", fwd_b_sel1, 2'b00);

    // Load-use with redirect: flush wins and a bubble enters EXE.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    exe_redirect = 1'b1;
    sample();
    check("redir_flush", flush_id, 1);
    check("redir_stall", stall_en, 0);
    step();
    exe_redirect = 1'b0;
    set_id(1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
    sample();
    check("redir_mem_a", fwd_a_sel, 2'b10);
    check("redir_bubble_b", fwd_b_sel, 2'b00);
    check("redir_flush_cnt", flush_cnt, PERF);
    check("redir_stall_cnt", stall_cnt, 0);

    // Reset asserted in the middle of a load-use stall.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    check("midrst_pre_stall", stall_en, 1);
    step();
    sample();
    check("midrst_held_stall", stall_en, 0);
    // The held reader now sees the load in MEM; re-arm a fresh load-use and reset into it.
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    sample();
    check("midrst_stall2", stall_en, 1);
    rst = 1'b1;
    #1;
    check("midrst_during_stall", stall_en, 0);
    step();
    rst = 1'b0;
    sample();
    check("midrst_after_stall", stall_en, 0);
    check("midrst_after_sel_a", fwd_a_sel, 2'b00);
    check("midrst_after_sel_b", fwd_b_sel, 2'b00);
    check("midrst_after_flush", flush_id, 0);
    check("midrst_after_cnt", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage CPU; the successor to the decoder-side forwarding logic, where stall generation was stubbed to 0.
- Keeps an internal shadow pipeline (EXE/MEM/WB) of destination-register metadata, so it needs only ID-stage decode fields and the EXE redirect.
- Generates load-use and depth-limited stalls, redirect flushes and per-operand forwarding selects.
- Forwarding depth and register-address width are parametrised.

Parameters:
- REG_AW, 5, register address width.
- FWD_DEPTH, 3, forwarding stages: 1=EXE only, 2=+MEM, 3=+WB. Legal range 1..3.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- id_rd  in  REG_AW  destination register.
- id_wreg  in  1  ID instruction writes a register.
- id_m2reg  in  1  ID instruction is a load.
- exe_redirect  in  1  taken branch or jump resolved in EXE this cycle.
- stall_en  out  1  hold PC and IF/ID; insert bubble into EXE.
- flush_id  out  1  squash IF/ID contents.
- fwd_a_sel, fwd_b_sel  out  2  operand source: 00 regfile, 01 EXE result, 10 MEM result, 11 WB result.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Optional Feature).

Behaviour:
- Shadow pipe: three entries (EXE, MEM, WB), each holding {v, rd, wreg, m2reg}. All entries are cleared on rst.
- Each clk: WB<=MEM, MEM<=EXE. EXE<=ID fields with v=id_valid, except v=0 (bubble) when stall_en or flush_id.
- An entry matches operand rsX iff: v & wreg & rd==rsX & rsX!=0 & rsX_used & id_valid. Register 0 never matches.
- Priority: the youngest match wins (EXE > MEM > WB). Older matches are ignored.
- Distance of the winning match: d=1 (EXE), 2 (MEM), 3 (WB).
- The match is forwardable iff d<=FWD_DEPTH and not (m2reg & d==1).
- Forwardable: sel = d (01/10/11).
- Not forwardable: stall_en=1 and sel=00.
- No match: sel=00.
- stall_en is the OR over both operands.
- stall_en, flush_id and the selects are combinational from the ID inputs and the registered shadow pipe. Zero latency; valid in the same cycle.
- Load-use with FWD_DEPTH>=2: exactly one stall cycle; the next cycle forwards from MEM (10).
- FWD_DEPTH=1: a producer stalls ID until it leaves WB (up to 3 cycles); the regfile write is then visible.
- flush_id = exe_redirect. It squashes the ID instruction only; the EXE entry itself retires normally.
- Redirect and stall in the same cycle: flush wins. stall_en is forced to 0, and a bubble enters EXE.
- Outputs while rst=1: stall_en=0, flush_id=0, sels=00, counters=0. The shadow pipe is invalidated the same edge, so the first cycle after reset never stalls.
- rst mid-stall: the stall is dropped the cycle after the reset edge. No residual hazards.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each clk with stall_en=1.
  - flush_cnt increments on each clk with flush_id=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0, no counter flops; ports remain present.

Decomposition:
- Package pipe_ctrl_pkg:
  - FWD_* select localparams: FWD_REG=2'b00, FWD_EXE=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - Shadow-entry struct typedef.
  - Default REG_AW.
- Sub-module haz_operand_chk (instantiated twice, one per operand):
  - Inputs: one rs, its used bit, the three shadow entries.
  - Outputs: sel and a per-operand stall request.

Test Plan:
- add r3 in EXE; ID add reads rs1=r3 -> fwd_a_sel=01, stall_en=0; next cycle with r3 in MEM and the reader advanced, no stall.
- lw r5 in EXE; ID reads rs2=r5, FWD_DEPTH=3 -> stall_en=1 for one cycle, then fwd_b_sel=10; stall_cnt=1 when PIPE_HAZARD_PERF_CNT_EN is defined.
- r4 written by both EXE and MEM entries; ID reads r4 -> fwd_a_sel=01 (youngest wins).
- Writer to r0 in EXE; ID reads r0 -> sel=00, stall_en=0.
- FWD_DEPTH=1, add r7 in EXE; ID reads r7 -> 0 stall cycles while r7 is in EXE, then stall_en=1 for 2 cycles (MEM, WB), then sel=00.
- lw-use stall coincident with exe_redirect=1 -> flush_id=1, stall_en=0, EXE bubble; rst asserted mid-stall -> all outputs 0 next cycle.
